frogger_game_ctrl: RTL and testbench
====================================

Name: frogger_game_ctrl

Overview:
- Game sequencer for the Frogger VGA display.
- Owns the frog's grid position, the enemy x-positions for each lane, the frame-based movement timing, collision detection, lives, score and the game-phase FSM.
- Feeds the pixel renderer, which only reads these outputs. Runs on the board clock alongside the VGA driver.
- Screen is 10 rows of 48 px: row 0 is start (top), rows 1..LANES are traffic lanes, row LANES+1 is goal. There are 20 columns of 32 px.

Parameters:
- LANES, 8, number of traffic lanes. Frog rows run 0..LANES+1.
- NCOLS, 20, frog columns; each column is 32 px wide.
- SCREEN_W, 640, visible width in px; enemy x wraps at this value.
- ENEMY_W, 32, enemy width in px.
- ENEMY_STEP, 8, px moved per enemy step.
- STEP_FRAMES, 4, frame_tick pulses per enemy step.
- HOLD_FRAMES, 60, frames spent in HIT or WIN before returning to play.
- LIVES, 3, lives loaded at start.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame, synchronous to clock.
- start_req  in  1  one-cycle pulse; starts a new game.
- up_req, left_req, right_req  in  1 each  one-cycle move pulses, already debounced.
- frog_row  out  4  current frog row.
- frog_col  out  5  current frog column.
- enemy_x  out  LANES*10  packed enemy left-edge x per lane; lane i occupies bits [10i+9:10i].
- game_state  out  3  IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4.
- lives  out  2  remaining lives.
- score  out  8  crossings completed; saturates at 255.
- hit_pulse  out  1  one cycle on each collision.
- win_pulse  out  1  one cycle on each goal reach.

Behaviour:
- Reset (async assert, sync release) sets:
  - game_state=IDLE, frog_row=0, frog_col=NCOLS/2 (10), lives=LIVES, score=0.
  - enemy_x[i] = (i*80) mod SCREEN_W.
  - hit_pulse=0, win_pulse=0, step and hold counters=0.
- All outputs are registered. Outputs update on the edge after the causing input pulse (latency 1).
- IDLE:
  - Ignores move requests. Enemies frozen.
  - start_req -> PLAY, loading lives=LIVES, score=0, frog at (0,10), enemies at their initial positions.
- PLAY, moves:
  - One move per cycle, priority up > left > right.
  - left at col 0 and right at col NCOLS-1 are ignored.
  - up from row LANES goes to row LANES+1 and triggers WIN on the same edge.
- PLAY, collision:
  - Evaluated combinationally from the current registers only.
  - Applies when frog_row is in 1..LANES. Let L = frog_row-1 and fx = frog_col*32.
  - Overlap condition: enemy_x[L] < fx+32 AND fx < enemy_x[L]+ENEMY_W. Unwrapped compare; the portion of an enemy past SCREEN_W never collides.
  - On overlap at an edge: game_state<=HIT, lives<=lives-1, frog<=(0,10), hit_pulse=1 for one cycle.
  - Any move request that same cycle is discarded.
  - Collision outranks win.
- Enemy stepping:
  - Enemies move in PLAY, HIT and WIN; frozen in IDLE and OVER.
  - The step counter increments on frame_tick. At STEP_FRAMES-1 it wraps to 0 and every lane steps.
  - Even lanes move right: x+ENEMY_STEP; a result >= SCREEN_W wraps to x+ENEMY_STEP-SCREEN_W.
  - Odd lanes move left: x-ENEMY_STEP; if x < ENEMY_STEP, x becomes x+SCREEN_W-ENEMY_STEP.
  - Use 11-bit intermediate arithmetic; the stored value is always < SCREEN_W.
  - A step on the same edge as a collision still applies. The collision uses the pre-step value.
- HIT:
  - The hold counter counts frame_tick pulses. At HOLD_FRAMES it clears and exits.
  - Exit to PLAY if lives>0, otherwise OVER. Move requests are ignored.
- WIN:
  - Entry edge: score<=score+1 (saturating at 255), win_pulse=1 for one cycle.
  - Frog reset to (0,10) on exit.
  - Holds HOLD_FRAMES frames, then returns to PLAY. Lives unchanged.
- OVER:
  - Holds frog at (0,10), lives=0, score held.
  - start_req behaves as in IDLE.
- start_req in PLAY, HIT or WIN is ignored.
- Reset asserted mid-game returns to the full reset state immediately, regardless of counters.
- Move or start pulses arriving together with frame_tick are handled independently; both take effect.

Test Plan:
- Release reset, no stimulus -> game_state=0, frog (0,10), lives=3, score=0, enemy_x lane0=0, lane1=80, lane7=560.
- start_req, then 9 up_req spaced apart with the enemies placed clear of column 10 -> frog_row steps 1..9. The ninth pulse gives game_state=WIN, win_pulse for one cycle, score=1. After 60 frame_ticks -> PLAY with frog (0,10).
- start_req, then up_req, then left_req x7 -> frog (1,3), fx=96. Drive frame_ticks until lane0 enemy_x=72 (overlap) -> hit_pulse, lives=2, game_state=HIT, frog (0,10).
- Three collisions with holds in between -> lives 3->2->1->0, final state OVER. A later start_req -> PLAY, lives=3, score=0.
- Lane0 at x=632, one step -> x=0. Lane1 at x=0, one step -> x=632. With STEP_FRAMES=4, no step occurs on the first 3 frame_ticks.
- In PLAY at col 0, assert up_req+left_req in the same cycle -> row+1, col stays 0. Then left_req alone at col 0 -> no change. Then right_req at col 19 -> no change.

Source files
------------

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: frog position, enemy lanes, collisions,
// lives, score and game-phase FSM feeding the pixel renderer.
module frogger_game_ctrl #(
    parameter int LANES       = 8,
    parameter int NCOLS       = 20,
    parameter int SCREEN_W    = 640,
    parameter int ENEMY_W     = 32,
    parameter int ENEMY_STEP  = 8,
    parameter int STEP_FRAMES = 4,
    parameter int HOLD_FRAMES = 60,
    parameter int LIVES       = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  start_req,
    input  logic                  up_req,
    input  logic                  left_req,
    input  logic                  right_req,
    output logic [3:0]            frog_row,
    output logic [4:0]            frog_col,
    output logic [LANES*10-1:0]   enemy_x,
    output logic [2:0]            game_state,
    output logic [1:0]            lives,
    output logic [7:0]            score,
    output logic                  hit_pulse,
    output logic                  win_pulse
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_HIT  = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    localparam int COL_W    = 32;
    localparam int LANE_GAP = 80;

    localparam logic [3:0] LAST_LANE = 4'(LANES);
    localparam logic [3:0] GOAL_ROW  = 4'(LANES + 1);
    localparam logic [4:0] HOME_COL  = 5'(NCOLS / 2);
    localparam logic [4:0] LAST_COL  = 5'(NCOLS - 1);
    localparam logic [1:0] FULL_LIVES = 2'(LIVES);
    localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    logic [9:0]  ex      [LANES];
    logic [9:0]  ex_next [LANES];
    logic [7:0]  step_cnt;
    logic [7:0]  hold_cnt;

    logic [9:0]  lane_x;
    logic        in_lane;
    logic [10:0] fx;
    logic [10:0] ex_wide;
    logic        collide;
    logic        moving;
    logic        tick_run;
    logic        step_now;
    logic        restart;

    // Starting layout of the enemies, one every 80 px
    function automatic logic [9:0] init_x(input int i);
        return 10'((i * LANE_GAP) % SCREEN_W);
    endfunction

    // Pack the per-lane enemy registers onto the output bus
    always_comb begin
        enemy_x = '0;
        for (int i = 0; i < LANES; i++) begin
            enemy_x[i*10 +: 10] = ex[i];
        end
    end

    // Select the enemy sharing the frog's lane
    always_comb begin
        lane_x = '0;
        for (int i = 0; i < LANES; i++) begin
            if (frog_row == 4'(i + 1)) begin
                lane_x = ex[i];
            end
        end
    end

    // Overlap test on current registers; wrapped-off part never hits
    always_comb begin
        in_lane = (frog_row != 4'd0) && (frog_row <= LAST_LANE);
        fx      = 11'({frog_col, 5'b0});
        ex_wide = {1'b0, lane_x};
        collide = (game_state == S_PLAY) && in_lane &&
                  (ex_wide < fx + 11'(COL_W)) &&
                  (fx < ex_wide + 11'(ENEMY_W));
    end

    // Frame pacing: enemies only advance while a game is running
    always_comb begin
        moving   = (game_state == S_PLAY) ||
                   (game_state == S_HIT)  ||
                   (game_state == S_WIN);
        tick_run = moving && frame_tick;
        step_now = tick_run && (step_cnt == STEP_LAST);
        restart  = start_req &&
                   ((game_state == S_IDLE) || (game_state == S_OVER));
    end

    // Next enemy positions: even lanes go right, odd lanes go left
    always_comb begin
        logic [10:0] sum;
        for (int i = 0; i < LANES; i++) begin
            sum        = {1'b0, ex[i]} + 11'(ENEMY_STEP);
            ex_next[i] = ex[i];
            if (i % 2 == 0) begin
                if (sum >= 11'(SCREEN_W)) begin
                    ex_next[i] = 10'(sum - 11'(SCREEN_W));
                end else begin
                    ex_next[i] = sum[9:0];
                end
            end else begin
                if (ex[i] < 10'(ENEMY_STEP)) begin
                    ex_next[i] = 10'({1'b0, ex[i]} +
                                 11'(SCREEN_W - ENEMY_STEP));
                end else begin
                    ex_next[i] = ex[i] - 10'(ENEMY_STEP);
                end
            end
        end
    end

    // Step counter and enemy position registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
            for (int i = 0; i < LANES; i++) begin
                ex[i] <= init_x(i);
            end
        end else if (restart) begin
            step_cnt <= '0;
            for (int i = 0; i < LANES; i++) begin
                ex[i] <= init_x(i);
            end
        end else if (tick_run) begin
            if (step_now) begin
                step_cnt <= '0;
                for (int i = 0; i < LANES; i++) begin
                    ex[i] <= ex_next[i];
                end
            end else begin
                step_cnt <= step_cnt + 8'd1;
            end
        end
    end

    // Game-phase FSM with frog, lives, score and event pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            game_state <= S_IDLE;
            frog_row   <= '0;
            frog_col   <= HOME_COL;
            lives      <= FULL_LIVES;
            score      <= '0;
            hold_cnt   <= '0;
            hit_pulse  <= 1'b0;
            win_pulse  <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            win_pulse <= 1'b0;
            case (game_state)
                S_IDLE, S_OVER: begin
                    if (start_req) begin
                        game_state <= S_PLAY;
                        lives      <= FULL_LIVES;
                        score      <= '0;
                        frog_row   <= '0;
                        frog_col   <= HOME_COL;
                        hold_cnt   <= '0;
                    end
                end
                S_PLAY: begin
                    if (collide) begin
                        game_state <= S_HIT;
                        lives      <= lives - 2'd1;
                        frog_row   <= '0;
                        frog_col   <= HOME_COL;
                        hold_cnt   <= '0;
                        hit_pulse  <= 1'b1;
                    end else if (up_req) begin
                        if (frog_row == LAST_LANE) begin
                            frog_row   <= GOAL_ROW;
                            game_state <= S_WIN;
                            hold_cnt   <= '0;
                            win_pulse  <= 1'b1;
                            if (score != 8'hFF) begin
                                score <= score + 8'd1;
                            end
                        end else begin
                            frog_row <= frog_row + 4'd1;
                        end
                    end else if (left_req) begin
                        if (frog_col != 5'd0) begin
                            frog_col <= frog_col - 5'd1;
                        end
                    end else if (right_req) begin
                        if (frog_col != LAST_COL) begin
                            frog_col <= frog_col + 5'd1;
                        end
                    end
                end
                S_HIT: begin
                    if (frame_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt   <= '0;
                            game_state <= (lives != 2'd0) ? S_PLAY
                                                          : S_OVER;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                S_WIN: begin
                    if (frame_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt   <= '0;
                            game_state <= S_PLAY;
                            frog_row   <= '0;
                            frog_col   <= HOME_COL;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    game_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Randomised and directed bench for frogger_game_ctrl against a
// rule-level game model.
module tb_frogger_game_ctrl;

    localparam int LANES       = 8;
    localparam int NCOLS       = 20;
    localparam int SCREEN_W    = 640;
    localparam int ENEMY_W     = 32;
    localparam int ENEMY_STEP  = 8;
    localparam int STEP_FRAMES = 4;
    localparam int HOLD_FRAMES = 60;
    localparam int LIVES       = 3;
    localparam int HOME        = NCOLS / 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                frame_tick = 1'b0;
    logic                start_req = 1'b0;
    logic                up_req = 1'b0;
    logic                left_req = 1'b0;
    logic                right_req = 1'b0;
    logic [3:0]          frog_row;
    logic [4:0]          frog_col;
    logic [LANES*10-1:0] enemy_x;
    logic [2:0]          game_state;
    logic [1:0]          lives;
    logic [7:0]          score;
    logic                hit_pulse;
    logic                win_pulse;

    int n_vec = 0;
    int n_err = 0;

    int m_state, m_row, m_col, m_lives, m_score;
    int m_hit, m_win, m_frames, m_hold;
    int m_x [LANES];

    frogger_game_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start_req  (start_req),
        .up_req     (up_req),
        .left_req   (left_req),
        .right_req  (right_req),
        .frog_row   (frog_row),
        .frog_col   (frog_col),
        .enemy_x    (enemy_x),
        .game_state (game_state),
        .lives      (lives),
        .score      (score),
        .hit_pulse  (hit_pulse),
        .win_pulse  (win_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_row = 0; m_col = HOME;
        m_lives = LIVES; m_score = 0;
        m_hit = 0; m_win = 0; m_frames = 0; m_hold = 0;
        for (int i = 0; i < LANES; i++) m_x[i] = (i * 80) % SCREEN_W;
    endtask

    // One clock of game rules, expressed in plain integer terms
    task automatic model_step(input bit ft, input bit st, input bit up,
                              input bit lf, input bit rt);
        bit running;
        bit crash;
        int lane;
        int fx;
        running = (m_state >= 1 && m_state <= 3);
        crash = 0;
        if (m_state == 1 && m_row >= 1 && m_row <= LANES) begin
            lane = m_row - 1;
            fx = m_col * 32;
            crash = (m_x[lane] < fx + 32) && (fx < m_x[lane] + ENEMY_W);
        end
        m_hit = 0;
        m_win = 0;
        case (m_state)
            0, 4: if (st) begin
                m_state = 1; m_lives = LIVES; m_score = 0;
                m_row = 0; m_col = HOME; m_frames = 0; m_hold = 0;
                for (int i = 0; i < LANES; i++) m_x[i] = (i * 80) % SCREEN_W;
            end
            1: begin
                if (crash) begin
                    m_state = 2; m_lives--; m_row = 0; m_col = HOME;
                    m_hold = 0; m_hit = 1;
                end else if (up) begin
                    m_row++;
                    if (m_row == LANES + 1) begin
                        m_state = 3; m_win = 1; m_hold = 0;
                        if (m_score < 255) m_score++;
                    end
                end else if (lf) begin
                    if (m_col > 0) m_col--;
                end else if (rt) begin
                    if (m_col < NCOLS - 1) m_col++;
                end
            end
            2: if (ft) begin
                m_hold++;
                if (m_hold == HOLD_FRAMES) begin
                    m_hold = 0;
                    m_state = (m_lives > 0) ? 1 : 4;
                end
            end
            3: if (ft) begin
                m_hold++;
                if (m_hold == HOLD_FRAMES) begin
                    m_hold = 0; m_state = 1; m_row = 0; m_col = HOME;
                end
            end
            default: ;
        endcase
        if (running && ft) begin
            m_frames++;
            if (m_frames == STEP_FRAMES) begin
                m_frames = 0;
                for (int i = 0; i < LANES; i++) begin
                    if (i % 2 == 0) m_x[i] = (m_x[i] + ENEMY_STEP) % SCREEN_W;
                    else m_x[i] = (m_x[i] - ENEMY_STEP + SCREEN_W) % SCREEN_W;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("state", int'(game_state), m_state);
        check("row", int'(frog_row), m_row);
        check("col", int'(frog_col), m_col);
        check("lives", int'(lives), m_lives);
        check("score", int'(score), m_score);
        check("hit", int'(hit_pulse), m_hit);
        check("win", int'(win_pulse), m_win);
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("ex%0d", i), int'(enemy_x[i*10 +: 10]), m_x[i]);
        end
    endtask

    task automatic cyc(input bit ft, input bit st, input bit up,
                       input bit lf, input bit rt);
        @(negedge clock);
        frame_tick = ft; start_req = st;
        up_req = up; left_req = lf; right_req = rt;
        model_step(ft, st, up, lf, rt);
        @(posedge clock);
        #1;
        compare_all();
        frame_tick = 0; start_req = 0;
        up_req = 0; left_req = 0; right_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(negedge clock);
        reset = 1;
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic hold_out();
        int n;
        n = 0;
        while ((m_state == 2 || m_state == 3) && n < 200) begin
            cyc(1, 0, 0, 0, 0);
            n++;
        end
        check("hold_done", int'(m_state == 2 || m_state == 3), 0);
    endtask

    task automatic play_until_hit();
        int n;
        n = 0;
        cyc(0, 0, 1, 0, 0);
        while (m_hit == 0 && n < 3000) begin
            if (m_col > 3) cyc(0, 0, 0, 1, 0);
            else cyc(1, 0, 0, 0, 0);
            n++;
        end
        check("hit_seen", m_hit, 1);
    endtask

    initial begin
        model_reset();
        #2 reset = 0;
        repeat (3) @(negedge clock);
        #1;
        compare_all();
        check("rst_state", int'(game_state), 0);
        check("rst_col", int'(frog_col), 10);
        check("rst_lives", int'(lives), 3);
        check("rst_lane1", int'(enemy_x[19:10]), 80);
        check("rst_lane7", int'(enemy_x[79:70]), 560);
        @(negedge clock);
        reset = 1;
        repeat (3) cyc(0, 0, 1, 0, 0);

        // Crossing to the goal from column 11, which no frozen enemy covers
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            cyc(0, 0, 1, 0, 0);
            if (k < 8) begin
                check("cross_row", int'(frog_row), k + 1);
                cyc(0, 0, 0, 0, 0);
            end
        end
        check("win_state", int'(game_state), 3);
        check("win_pulse", int'(win_pulse), 1);
        check("win_score", int'(score), 1);
        cyc(0, 1, 0, 0, 0);
        check("win_pulse_off", int'(win_pulse), 0);
        repeat (59) cyc(1, 0, 0, 0, 0);
        check("win_holding", int'(game_state), 3);
        cyc(1, 0, 0, 0, 0);
        check("win_exit", int'(game_state), 1);
        check("win_exit_row", int'(frog_row), 0);
        check("win_exit_col", int'(frog_col), 10);

        // Step pacing and the first collision
        do_reset();
        cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        check("nostep_l0", int'(enemy_x[9:0]), 0);
        check("nostep_l1", int'(enemy_x[19:10]), 80);
        cyc(1, 0, 0, 0, 0);
        check("step_l0", int'(enemy_x[9:0]), 8);
        check("step_l1", int'(enemy_x[19:10]), 72);
        play_until_hit();
        check("hit1_lives", int'(lives), 2);
        check("hit1_state", int'(game_state), 2);
        check("hit1_col", int'(frog_col), 10);
        hold_out();
        play_until_hit();
        hold_out();
        play_until_hit();
        hold_out();
        check("over_state", int'(game_state), 4);
        check("over_lives", int'(lives), 0);
        cyc(0, 1, 0, 0, 0);
        check("restart_state", int'(game_state), 1);
        check("restart_lives", int'(lives), 3);
        check("restart_score", int'(score), 0);

        // Column limits and move priority
        repeat (16) cyc(1, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 1);
        check("right_edge", int'(frog_col), 19);
        cyc(0, 0, 0, 0, 1);
        check("right_clamp", int'(frog_col), 19);
        repeat (19) cyc(0, 0, 0, 1, 0);
        check("left_edge", int'(frog_col), 0);
        cyc(0, 0, 1, 1, 0);
        check("upleft_row", int'(frog_row), 1);
        check("upleft_col", int'(frog_col), 0);
        cyc(0, 0, 0, 1, 0);
        check("left_clamp", int'(frog_col), 0);

        // Random play with an asynchronous reset in the middle
        for (int n = 0; n < 12000; n++) begin
            if (n == 6000) do_reset();
            cyc(bit'($urandom_range(0, 1)),
                $urandom_range(0, 63) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
